mread: RTL and testbench

MREAD -- requirements
Module: mread

---
 rtl/mread.sv | 181 ++++++++++++++++++
 tb/tb_mread.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mread.sv
// mread -- memory-read pipeline stage.
//
// Captures the execute-stage result (integer/CSR write-back, load request,
// store request) into a held entry whenever the stage is idle and not
// globally stalled. Aligned loads go through a short IDLE -> REQ -> WAIT
// handshake with the MMU read port; the returned word is formatted by
// funct3 and replaces the held integer write-back data. Misaligned loads
// skip the MMU, return 0 and raise a one-cycle LOAD_MISALIGN pulse.
// Stores are forwarded to the write stage for one non-stalled cycle.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   MEM_WAIT            global stall (MEMR_STALL is ORed into it upstream)
//   EXEC_REG_W_*        integer write-back from execute
//   EXEC_CSR_W_*        CSR write-back from execute
//   EXEC_LOAD_*         load request (valid, byte address, funct3)
//   EXEC_MEM_W_*        store request (valid, address, strobe, data)
//   DATA_RDEN/RADDR     MMU read request (word aligned)
//   DATA_RVALID/RDATA   MMU read response
//   MEMR_REG_W_*        integer write-back to write stage
//   MEMR_CSR_W_*        CSR write-back to write stage
//   MEMR_MEM_W_*        store forwarded to write stage
//   MEMR_STALL          load in flight
//   LOAD_MISALIGN       one-cycle misaligned-load fault pulse
module mread (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic [4:0]  EXEC_REG_W_RD,
  input  logic [31:0] EXEC_REG_W_DATA,
  input  logic [11:0] EXEC_CSR_W_ADDR,
  input  logic [31:0] EXEC_CSR_W_DATA,
  input  logic        EXEC_LOAD_VALID,
  input  logic [31:0] EXEC_LOAD_ADDR,
  input  logic [2:0]  EXEC_LOAD_FUNCT3,
  input  logic        EXEC_MEM_W_VALID,
  input  logic [31:0] EXEC_MEM_W_ADDR,
  input  logic [3:0]  EXEC_MEM_W_STRB,
  input  logic [31:0] EXEC_MEM_W_DATA,
  output logic        DATA_RDEN,
  output logic [31:0] DATA_RADDR,
  input  logic        DATA_RVALID,
  input  logic [31:0] DATA_RDATA,
  output logic [4:0]  MEMR_REG_W_RD,
  output logic [31:0] MEMR_REG_W_DATA,
  output logic [11:0] MEMR_CSR_W_ADDR,
  output logic [31:0] MEMR_CSR_W_DATA,
  output logic        MEMR_MEM_W_VALID,
  output logic [31:0] MEMR_MEM_W_ADDR,
  output logic [3:0]  MEMR_MEM_W_STRB,
  output logic [31:0] MEMR_MEM_W_DATA,
  output logic        MEMR_STALL,
  output logic        LOAD_MISALIGN
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic [31:0] reg_data_q;
  logic [11:0] csr_addr_q;
  logic [31:0] csr_data_q;
  logic [31:0] ld_addr_q;
  logic [2:0]  ld_f3_q;
  logic        st_valid_q;
  logic [31:0] st_addr_q;
  logic [3:0]  st_strb_q;
  logic [31:0] st_data_q;
  logic        misalign_q;

  logic capture;
  logic ld_misalign;

  assign capture = (state == S_IDLE) && !MEM_WAIT;

  // funct3[1:0]==01 covers both LH and LHU.
  assign ld_misalign = EXEC_LOAD_VALID &&
                       (((EXEC_LOAD_FUNCT3[1:0] == 2'b01) && EXEC_LOAD_ADDR[0]) ||
                        ((EXEC_LOAD_FUNCT3 == 3'b010) && (EXEC_LOAD_ADDR[1:0] != 2'b00)));

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b010:  fmt_load = d;
      3'b100:  fmt_load = {24'b0, b};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = '0;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      rd_q       <= '0;
      reg_data_q <= '0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      ld_addr_q  <= '0;
      ld_f3_q    <= '0;
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_strb_q  <= '0;
      st_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (capture) begin
            rd_q       <= EXEC_REG_W_RD;
            // A load's write-back value comes from memory (or 0 on fault).
            reg_data_q <= EXEC_LOAD_VALID ? 32'h0 : EXEC_REG_W_DATA;
            csr_addr_q <= EXEC_CSR_W_ADDR;
            csr_data_q <= EXEC_CSR_W_DATA;
            ld_addr_q  <= EXEC_LOAD_ADDR;
            ld_f3_q    <= EXEC_LOAD_FUNCT3;
            // Load wins over a simultaneous store.
            st_valid_q <= EXEC_MEM_W_VALID && !EXEC_LOAD_VALID;
            st_addr_q  <= EXEC_MEM_W_ADDR;
            st_strb_q  <= EXEC_MEM_W_STRB;
            st_data_q  <= EXEC_MEM_W_DATA;
            misalign_q <= ld_misalign;
            if (EXEC_LOAD_VALID && !ld_misalign) state <= S_REQ;
          end
        end
        S_REQ:  state <= S_WAIT;
        S_WAIT: begin
          if (DATA_RVALID) begin
            reg_data_q <= fmt_load(ld_f3_q, ld_addr_q[1:0], DATA_RDATA);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by RST so they read 0 even before the first reset edge.
  always_comb begin
    DATA_RDEN        = 1'b0;
    DATA_RADDR       = '0;
    MEMR_REG_W_RD    = '0;
    MEMR_REG_W_DATA  = '0;
    MEMR_CSR_W_ADDR  = '0;
    MEMR_CSR_W_DATA  = '0;
    MEMR_MEM_W_VALID = 1'b0;
    MEMR_MEM_W_ADDR  = '0;
    MEMR_MEM_W_STRB  = '0;
    MEMR_MEM_W_DATA  = '0;
    MEMR_STALL       = 1'b0;
    LOAD_MISALIGN    = 1'b0;
    if (!RST) begin
      MEMR_STALL = (state != S_IDLE);
      if (state == S_REQ) begin
        DATA_RDEN  = 1'b1;
        DATA_RADDR = {ld_addr_q[31:2], 2'b00};
      end
      MEMR_REG_W_RD    = MEMR_STALL ? 5'd0 : rd_q;
      MEMR_REG_W_DATA  = reg_data_q;
      MEMR_CSR_W_ADDR  = csr_addr_q;
      MEMR_CSR_W_DATA  = csr_data_q;
      MEMR_MEM_W_VALID = st_valid_q && (state == S_IDLE) && !MEM_WAIT;
      MEMR_MEM_W_ADDR  = st_addr_q;
      MEMR_MEM_W_STRB  = st_strb_q;
      MEMR_MEM_W_DATA  = st_data_q;
      LOAD_MISALIGN    = misalign_q;
    end
  end

endmodule

// File: tb/tb_mread.sv
// Directed testbench for mread. Stimulus pushes expectations into queues;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_mread;

  logic        CLK = 1'b0;
  logic        RST, MEM_WAIT;
  logic [4:0]  EXEC_REG_W_RD;
  logic [31:0] EXEC_REG_W_DATA;
  logic [11:0] EXEC_CSR_W_ADDR;
  logic [31:0] EXEC_CSR_W_DATA;
  logic        EXEC_LOAD_VALID;
  logic [31:0] EXEC_LOAD_ADDR;
  logic [2:0]  EXEC_LOAD_FUNCT3;
  logic        EXEC_MEM_W_VALID;
  logic [31:0] EXEC_MEM_W_ADDR;
  logic [3:0]  EXEC_MEM_W_STRB;
  logic [31:0] EXEC_MEM_W_DATA;
  logic        DATA_RDEN;
  logic [31:0] DATA_RADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic [11:0] MEMR_CSR_W_ADDR;
  logic [31:0] MEMR_CSR_W_DATA;
  logic        MEMR_MEM_W_VALID;
  logic [31:0] MEMR_MEM_W_ADDR;
  logic [3:0]  MEMR_MEM_W_STRB;
  logic [31:0] MEMR_MEM_W_DATA;
  logic        MEMR_STALL;
  logic        LOAD_MISALIGN;

  always #5 CLK = ~CLK;

  mread dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
    .EXEC_REG_W_RD(EXEC_REG_W_RD), .EXEC_REG_W_DATA(EXEC_REG_W_DATA),
    .EXEC_CSR_W_ADDR(EXEC_CSR_W_ADDR), .EXEC_CSR_W_DATA(EXEC_CSR_W_DATA),
    .EXEC_LOAD_VALID(EXEC_LOAD_VALID), .EXEC_LOAD_ADDR(EXEC_LOAD_ADDR),
    .EXEC_LOAD_FUNCT3(EXEC_LOAD_FUNCT3),
    .EXEC_MEM_W_VALID(EXEC_MEM_W_VALID), .EXEC_MEM_W_ADDR(EXEC_MEM_W_ADDR),
    .EXEC_MEM_W_STRB(EXEC_MEM_W_STRB), .EXEC_MEM_W_DATA(EXEC_MEM_W_DATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RADDR(DATA_RADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .MEMR_REG_W_RD(MEMR_REG_W_RD), .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
    .MEMR_CSR_W_ADDR(MEMR_CSR_W_ADDR), .MEMR_CSR_W_DATA(MEMR_CSR_W_DATA),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID), .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB), .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
    .MEMR_STALL(MEMR_STALL), .LOAD_MISALIGN(LOAD_MISALIGN)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; int stall; } ld_t;
  typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } st_t;
  typedef struct { int tag; logic [184:0] v; } snap_t;

  ld_t         ld_q[$];
  st_t         st_q[$];
  logic [31:0] raddr_q[$];
  logic [4:0]  mis_q[$];
  snap_t       snap_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int snap_tag = 0;
  bit done = 1'b0;
  bit fin  = 1'b0;

  logic [184:0] obs;
  assign obs = {DATA_RDEN, DATA_RADDR, MEMR_REG_W_RD, MEMR_REG_W_DATA,
                MEMR_CSR_W_ADDR, MEMR_CSR_W_DATA, MEMR_MEM_W_VALID,
                MEMR_MEM_W_ADDR, MEMR_MEM_W_STRB, MEMR_MEM_W_DATA,
                MEMR_STALL, LOAD_MISALIGN};

  function automatic logic [184:0] mk(input logic [4:0] rd, input logic [31:0] rdat,
                                      input logic [11:0] ca, input logic [31:0] cd);
    return {1'b0, 32'h0, rd, rdat, ca, cd, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};
  endfunction

  task automatic cmp(input string nm, input logic [184:0] act, input logic [184:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: all comparisons live here.
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  always @(negedge CLK) begin
    if (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      cmp($sformatf("snap%0d", s.tag), obs, s.v);
    end
    if (DATA_RDEN) begin
      if (raddr_q.size() == 0) cmp("unexpected_rden", 185'(DATA_RADDR), 185'h0 - 185'h1);
      else cmp("raddr", 185'(DATA_RADDR), 185'(raddr_q.pop_front()));
    end
    if (MEMR_MEM_W_VALID) begin
      if (st_q.size() == 0) cmp("unexpected_store", 185'(MEMR_MEM_W_ADDR), 185'h0 - 185'h1);
      else begin
        st_t e;
        e = st_q.pop_front();
        cmp("st_addr", 185'(MEMR_MEM_W_ADDR), 185'(e.addr));
        cmp("st_strb", 185'(MEMR_MEM_W_STRB), 185'(e.strb));
        cmp("st_data", 185'(MEMR_MEM_W_DATA), 185'(e.data));
      end
    end
    if (LOAD_MISALIGN) begin
      if (mis_q.size() == 0) cmp("unexpected_misalign", 185'(1), 185'(0));
      else begin
        logic [4:0] r;
        r = mis_q.pop_front();
        cmp("mis_rd", 185'(MEMR_REG_W_RD), 185'(r));
        cmp("mis_data", 185'(MEMR_REG_W_DATA), 185'(0));
        cmp("mis_stall_rden", 185'({MEMR_STALL, DATA_RDEN}), 185'(0));
      end
    end
    if (MEMR_STALL) cmp("rd_while_stall", 185'(MEMR_REG_W_RD), 185'(0));
    if (!RST && prev_stall && !MEMR_STALL) begin
      if (ld_q.size() == 0) cmp("unexpected_ld_result", 185'(MEMR_REG_W_DATA), 185'h0 - 185'h1);
      else begin
        ld_t e;
        e = ld_q.pop_front();
        cmp("ld_rd", 185'(MEMR_REG_W_RD), 185'(e.rd));
        cmp("ld_data", 185'(MEMR_REG_W_DATA), 185'(e.data));
        cmp("ld_stall_cycles", 185'(stall_cnt), 185'(e.stall));
      end
    end
    if (RST || !MEMR_STALL) stall_cnt = 0;
    else stall_cnt++;
    prev_stall = !RST && MEMR_STALL;
    if (done && !fin) begin
      cmp("ld_q_left", 185'(ld_q.size()), 185'(0));
      cmp("st_q_left", 185'(st_q.size()), 185'(0));
      cmp("raddr_q_left", 185'(raddr_q.size()), 185'(0));
      cmp("mis_q_left", 185'(mis_q.size()), 185'(0));
      cmp("snap_q_left", 185'(snap_q.size()), 185'(0));
      fin = 1'b1;
    end
  end

  task automatic snap(input logic [184:0] v);
    snap_q.push_back('{snap_tag, v});
    snap_tag++;
  endtask

  task automatic clr_exec();
    EXEC_REG_W_RD = '0;    EXEC_REG_W_DATA = '0;
    EXEC_CSR_W_ADDR = '0;  EXEC_CSR_W_DATA = '0;
    EXEC_LOAD_VALID = 1'b0; EXEC_LOAD_ADDR = '0; EXEC_LOAD_FUNCT3 = '0;
    EXEC_MEM_W_VALID = 1'b0; EXEC_MEM_W_ADDR = '0;
    EXEC_MEM_W_STRB = '0;  EXEC_MEM_W_DATA = '0;
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input int dly, input logic [31:0] rdata, input logic [31:0] exp,
                         input bit mis, input bit with_store);
    EXEC_LOAD_VALID = 1'b1; EXEC_LOAD_ADDR = a; EXEC_LOAD_FUNCT3 = f3;
    EXEC_REG_W_RD = rd; EXEC_REG_W_DATA = 32'h5555AAAA;
    if (with_store) begin
      EXEC_MEM_W_VALID = 1'b1; EXEC_MEM_W_ADDR = 32'h5000;
      EXEC_MEM_W_STRB = 4'hF;  EXEC_MEM_W_DATA = 32'h77777777;
    end
    MEM_WAIT = 1'b0;
    if (mis) mis_q.push_back(rd);
    else begin
      raddr_q.push_back({a[31:2], 2'b00});
      ld_q.push_back('{rd, exp, dly + 1});
    end
    @(posedge CLK); #1;
    clr_exec();
    if (!mis) begin
      MEM_WAIT = 1'b1;
      repeat (dly) @(posedge CLK);
      #1 DATA_RVALID = 1'b1; DATA_RDATA = rdata;
      @(posedge CLK); #1;
      DATA_RVALID = 1'b0; DATA_RDATA = '0; MEM_WAIT = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    EXEC_MEM_W_VALID = 1'b1; EXEC_MEM_W_ADDR = a; EXEC_MEM_W_STRB = s; EXEC_MEM_W_DATA = d;
    MEM_WAIT = 1'b0;
    st_q.push_back('{a, s, d});
    @(posedge CLK); #1;
    clr_exec();
    MEM_WAIT = 1'b1;
    repeat (2) @(posedge CLK);
    #1 MEM_WAIT = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; MEM_WAIT = 1'b0; DATA_RVALID = 1'b0; DATA_RDATA = '0;
    clr_exec();
    snap('0);
    @(posedge CLK); #1;
    // Load presented during reset must not be captured.
    EXEC_LOAD_VALID = 1'b1; EXEC_LOAD_ADDR = 32'h1004; EXEC_LOAD_FUNCT3 = 3'b010;
    EXEC_REG_W_RD = 5'd3;
    snap('0);
    @(posedge CLK); #1;
    clr_exec(); RST = 1'b0;
    snap('0);
    @(posedge CLK); #1;

    do_load(32'h1004, 3'b010, 5'd5,  3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    do_load(32'h1003, 3'b000, 5'd6,  1, 32'h80FFFFFF, 32'hFFFFFF80, 0, 0);
    do_load(32'h1003, 3'b100, 5'd7,  2, 32'h80FFFFFF, 32'h00000080, 0, 0);
    do_load(32'h1002, 3'b001, 5'd8,  1, 32'h80011234, 32'hFFFF8001, 0, 0);
    do_load(32'h1002, 3'b101, 5'd9,  1, 32'h80011234, 32'h00008001, 0, 0);
    do_load(32'h1000, 3'b001, 5'd10, 1, 32'h80011234, 32'h00001234, 0, 0);
    do_load(32'h1001, 3'b000, 5'd11, 1, 32'h00009A00, 32'hFFFFFF9A, 0, 0);
    do_load(32'h1000, 3'b011, 5'd12, 1, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    do_load(32'h2001, 3'b001, 5'd13, 0, 32'h0, 32'h0, 1, 0);
    do_load(32'h2002, 3'b010, 5'd14, 0, 32'h0, 32'h0, 1, 0);
    do_load(32'h2003, 3'b101, 5'd15, 0, 32'h0, 32'h0, 1, 0);
    do_store(32'h3000, 4'hF, 32'h12345678);
    do_store(32'h3006, 4'hC, 32'hA5A50000);
    do_load(32'h4000, 3'b010, 5'd16, 2, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1);

    // Plain write-back passthrough, then hold under MEM_WAIT.
    EXEC_REG_W_RD = 5'd3; EXEC_REG_W_DATA = 32'h0BADF00D;
    EXEC_CSR_W_ADDR = 12'h305; EXEC_CSR_W_DATA = 32'h00001234;
    @(posedge CLK); #1;
    snap(mk(5'd3, 32'h0BADF00D, 12'h305, 32'h00001234));
    MEM_WAIT = 1'b1;
    EXEC_REG_W_RD = 5'd9; EXEC_REG_W_DATA = 32'hFFFFFFFF;
    EXEC_CSR_W_ADDR = 12'h300; EXEC_CSR_W_DATA = 32'h1;
    @(posedge CLK); #1;
    snap(mk(5'd3, 32'h0BADF00D, 12'h305, 32'h00001234));
    MEM_WAIT = 1'b0; clr_exec();
    @(posedge CLK); #1;
    snap('0);

    // RVALID while idle is ignored.
    DATA_RVALID = 1'b1; DATA_RDATA = 32'hFFFF0000;
    @(posedge CLK); #1;
    DATA_RVALID = 1'b0; DATA_RDATA = '0;
    snap('0);
    @(posedge CLK); #1;

    // Reset while waiting on the MMU, then a late RVALID.
    EXEC_LOAD_VALID = 1'b1; EXEC_LOAD_ADDR = 32'h6000; EXEC_LOAD_FUNCT3 = 3'b010;
    EXEC_REG_W_RD = 5'd4;
    raddr_q.push_back(32'h6000);
    @(posedge CLK); #1;
    clr_exec(); MEM_WAIT = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    snap('0);
    @(posedge CLK); #1;
    RST = 1'b0; MEM_WAIT = 1'b0;
    snap('0);
    @(posedge CLK); #1;
    DATA_RVALID = 1'b1; DATA_RDATA = 32'h11111111;
    snap('0);
    @(posedge CLK); #1;
    DATA_RVALID = 1'b0; DATA_RDATA = '0;
    snap('0);
    repeat (3) @(posedge CLK);
    #1 done = 1'b1;
    wait (fin);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
